// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Main control FSM for the multicycle MIPS datapath. A Moore machine steps
// each instruction through fetch, decode and its execute/memory/write-back
// states. The datapath enables and mux selects come from this unit, and one
// shared memory serves both instruction fetch and data access.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low; forces FETCH immediately
//   op, funct     instr[31:26] / instr[5:0] from the instruction register
//   zero          ALU zero flag, used combinationally in BEQEX only
//   iord..pcsrc   datapath enables and mux selects (registered, Moore)
//   pcen          pcwrite | (branch & zero)
//   alucontrol    ALU operation, decoded from aluop and funct
//   halted        high while in HALT
//   state_o       current state, for debug
//
// state   | meaning
// FETCH   | read instruction at PC, load IR, PC <= PC+4
// DECODE  | read registers, precompute branch target
// MEMADR  | address = A + SignImm (lw/sw)
// MEMRD   | read data memory at ALUOut
// MEMWB   | write loaded data to rt
// MEMWR   | write B to memory at ALUOut
// EXECUTE | R-type ALU operation
// ALUWB   | write ALUOut to rd
// BEQEX   | compare A-B, branch when zero
// ADDIEX  | A + SignImm
// ADDIWB  | write ALUOut to rt
// JEX     | PC <= jump target
// HALT    | illegal opcode trap, left only by reset

module mips_multicycle_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b0,
    parameter int STATE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic               pcen,
    output logic [2:0]         alucontrol,
    output logic               halted,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = STATE_W'(0),
        S_DECODE  = STATE_W'(1),
        S_MEMADR  = STATE_W'(2),
        S_MEMRD   = STATE_W'(3),
        S_MEMWB   = STATE_W'(4),
        S_MEMWR   = STATE_W'(5),
        S_EXECUTE = STATE_W'(6),
        S_ALUWB   = STATE_W'(7),
        S_BEQEX   = STATE_W'(8),
        S_ADDIEX  = STATE_W'(9),
        S_ADDIWB  = STATE_W'(10),
        S_JEX     = STATE_W'(11),
        S_HALT    = STATE_W'(12)
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic [1:0] aluop;
        logic       halted;
    } ctrl_t;

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;

    // Outputs are registered by computing them for the state being entered.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR,
            S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            S_BEQEX:   begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_ADDIWB:  c.regwrite = 1'b1;
            S_JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            S_HALT:    c.halted = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    6'h23, 6'h2B: w_next = S_MEMADR;
                    6'h00:        w_next = S_EXECUTE;
                    6'h04:        w_next = S_BEQEX;
                    6'h08:        w_next = S_ADDIEX;
                    6'h02:        w_next = S_JEX;
                    default:      w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (op == 6'h23) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = S_MEMWB;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_FETCH;   // terminal states and unused encodings
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_for(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next);
        end
    end

    always_comb begin
        alucontrol = 3'b010;
        case (r_ctrl.aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            default: begin
                case (funct)
                    6'h20:   alucontrol = 3'b010;
                    6'h22:   alucontrol = 3'b110;
                    6'h24:   alucontrol = 3'b000;
                    6'h25:   alucontrol = 3'b001;
                    6'h2A:   alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
        endcase
    end

    assign iord     = r_ctrl.iord;
    assign memwrite = r_ctrl.memwrite;
    assign irwrite  = r_ctrl.irwrite;
    assign regdst   = r_ctrl.regdst;
    assign memtoreg = r_ctrl.memtoreg;
    assign regwrite = r_ctrl.regwrite;
    assign alusrca  = r_ctrl.alusrca;
    assign alusrcb  = r_ctrl.alusrcb;
    assign pcsrc    = r_ctrl.pcsrc;
    assign pcen     = r_ctrl.pcwrite | (r_ctrl.branch & zero);
    assign halted   = r_ctrl.halted;
    assign state_o  = r_state;

endmodule
